// File: rtl/sdcard_sector_reader_pkg.sv
// Shared definitions for the SD card single-sector reader: FSM states,
// SD protocol bytes, retry limits and CPU register map.
package sdcard_sector_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    R1,
    TOKEN,
    DATA,
    CRC,
    FIN
  } state_t;

  // SD protocol constants
  localparam logic [7:0] CMD17       = 8'h51;
  localparam logic [7:0] TOKEN_START = 8'hFE;
  localparam logic [7:0] IDLE_BYTE   = 8'hFF;

  // Retry limits (counted in exchanged bytes)
  localparam int R1_LIMIT    = 8;
  localparam int TOKEN_LIMIT = 4096;

  // Frame lengths
  localparam int CMD_BYTES    = 6;
  localparam int SECTOR_BYTES = 512;
  localparam int CRC_BYTES    = 2;

  // CPU register map
  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_LBA3 = 3'd1;  // LBA[31:24]
  localparam logic [2:0] REG_LBA2 = 3'd2;  // LBA[23:16]
  localparam logic [2:0] REG_LBA1 = 3'd3;  // LBA[15:8]
  localparam logic [2:0] REG_LBA0 = 3'd4;  // LBA[7:0]
  localparam logic [2:0] REG_DATA = 3'd5;
  localparam logic [2:0] REG_R1   = 3'd6;

  // Saturating increment for the 12-bit byte/retry counter
  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

endpackage

// File: rtl/sdcard_sector_reader_if.sv
// Bundle of the CPU register bus and the SPI byte-engine handshake.
// The reader itself connects through the slave modport.
interface sdcard_sector_reader_if;
  logic [2:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic       xfer_start;
  logic [7:0] xfer_tx;
  logic       xfer_busy;
  logic [7:0] xfer_rx;
  logic       sd_ss;

  modport master (
    output AD, DI, rw, cs, xfer_busy, xfer_rx,
    input  DO, xfer_start, xfer_tx, sd_ss
  );

  modport slave (
    input  AD, DI, rw, cs, xfer_busy, xfer_rx,
    output DO, xfer_start, xfer_tx, sd_ss
  );
endinterface

// File: rtl/sdcard_sector_reader_sector_buf.sv
// 512x8 sector buffer: one synchronous write port, one registered read port.
module sector_buf
  import sdcard_sector_reader_pkg::*;
(
  input  logic       clk,
  input  logic       wr_en,
  input  logic [8:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  input  logic [8:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [SECTOR_BYTES];

  // Write incoming sector bytes; read holds its last value when not enabled
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sdcard_sector_reader.sv
// SD card (SPI mode) single-block reader: issues CMD17 for the programmed
// LBA, waits for R1 and the start token, stores 512 data bytes in a local
// buffer and exposes status, LBA, data and R1 through a small register file.
module sdcard_sector_reader
  import sdcard_sector_reader_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  sdcard_sector_reader_if.slave bus
);

  state_t      state_reg;
  logic        busy_reg;
  logic        err_reg;
  logic        to_reg;
  logic [31:0] lba_reg;
  logic [7:0]  r1_reg;
  logic [8:0]  ptr_reg;
  logic [11:0] cnt_reg;
  logic        pending_reg;
  logic        busy_prev_reg;
  logic        xfer_start_reg;
  logic [7:0]  xfer_tx_reg;
  logic        sd_ss_reg;
  logic [7:0]  do_reg;
  logic        sel_buf_reg;

  logic        cpu_wr;
  logic        cpu_rd;
  logic        done;
  logic        issue;
  logic        buf_rd_en;
  logic        buf_wr_en;
  logic [7:0]  buf_rd_data;
  logic [7:0]  tx_byte;
  logic [7:0]  reg_rdata;

  assign cpu_wr    = bus.cs && !bus.rw;
  assign cpu_rd    = bus.cs && bus.rw;
  // Exchange completes on the busy 1->0 transition of an exchange we started
  assign done      = pending_reg && busy_prev_reg && !bus.xfer_busy;
  // Start a new exchange only when none is outstanding and the engine is idle
  assign issue     = (state_reg != IDLE) && !pending_reg && !bus.xfer_busy;
  assign buf_rd_en = cpu_rd && (bus.AD == REG_DATA) && !busy_reg;
  assign buf_wr_en = (state_reg == DATA) && done;

  // Data reads come straight from the buffer's read register, others from do_reg
  assign bus.DO         = sel_buf_reg ? buf_rd_data : do_reg;
  assign bus.xfer_start = xfer_start_reg;
  assign bus.xfer_tx    = xfer_tx_reg;
  assign bus.sd_ss      = sd_ss_reg;

  sector_buf u_sector_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (cnt_reg[8:0]),
    .wr_data (bus.xfer_rx),
    .rd_en   (buf_rd_en),
    .rd_addr (ptr_reg),
    .rd_data (buf_rd_data)
  );

  // Byte to transmit: the CMD17 frame during CMD, idle 0xFF everywhere else
  always_comb begin
    tx_byte = IDLE_BYTE;
    if (state_reg == CMD) begin
      case (cnt_reg[2:0])
        3'd0:    tx_byte = CMD17;
        3'd1:    tx_byte = lba_reg[31:24];
        3'd2:    tx_byte = lba_reg[23:16];
        3'd3:    tx_byte = lba_reg[15:8];
        3'd4:    tx_byte = lba_reg[7:0];
        default: tx_byte = IDLE_BYTE;
      endcase
    end
  end

  // Register read mux (data port reads while busy return 0xFF)
  always_comb begin
    reg_rdata = 8'h00;
    case (bus.AD)
      REG_CTRL: reg_rdata = {busy_reg, err_reg, to_reg, 5'b0};
      REG_LBA3: reg_rdata = lba_reg[31:24];
      REG_LBA2: reg_rdata = lba_reg[23:16];
      REG_LBA1: reg_rdata = lba_reg[15:8];
      REG_LBA0: reg_rdata = lba_reg[7:0];
      REG_DATA: reg_rdata = 8'hFF;
      REG_R1:   reg_rdata = r1_reg;
      default:  reg_rdata = 8'h00;
    endcase
  end

  // Register file and read FSM; all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      busy_reg       <= 1'b0;
      err_reg        <= 1'b0;
      to_reg         <= 1'b0;
      lba_reg        <= '0;
      r1_reg         <= 8'hFF;
      ptr_reg        <= '0;
      cnt_reg        <= '0;
      pending_reg    <= 1'b0;
      busy_prev_reg  <= 1'b0;
      xfer_start_reg <= 1'b0;
      xfer_tx_reg    <= 8'hFF;
      sd_ss_reg      <= 1'b1;
      do_reg         <= 8'h00;
      sel_buf_reg    <= 1'b0;
    end else begin
      busy_prev_reg  <= bus.xfer_busy;
      xfer_start_reg <= 1'b0;

      if (cpu_rd) begin
        sel_buf_reg <= buf_rd_en;
        do_reg      <= reg_rdata;
        if (buf_rd_en) ptr_reg <= ptr_reg + 9'd1;
      end

      if (cpu_wr) begin
        case (bus.AD)
          REG_CTRL: begin
            if (bus.DI[0] && !busy_reg) begin
              busy_reg    <= 1'b1;
              err_reg     <= 1'b0;
              to_reg      <= 1'b0;
              sd_ss_reg   <= 1'b0;
              ptr_reg     <= '0;
              cnt_reg     <= '0;
              pending_reg <= 1'b0;
              state_reg   <= CMD;
            end
          end
          REG_LBA3: if (!busy_reg) lba_reg[31:24] <= bus.DI;
          REG_LBA2: if (!busy_reg) lba_reg[23:16] <= bus.DI;
          REG_LBA1: if (!busy_reg) lba_reg[15:8]  <= bus.DI;
          REG_LBA0: if (!busy_reg) lba_reg[7:0]   <= bus.DI;
          REG_DATA: ptr_reg <= '0;
          default: ;
        endcase
      end

      if (issue) begin
        xfer_start_reg <= 1'b1;
        xfer_tx_reg    <= tx_byte;
        pending_reg    <= 1'b1;
      end else if (done) begin
        pending_reg <= 1'b0;
        case (state_reg)
          CMD: begin
            if (cnt_reg == 12'(CMD_BYTES - 1)) begin
              state_reg <= R1;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= sat_inc(cnt_reg);
            end
          end
          R1: begin
            if (!bus.xfer_rx[7]) begin
              r1_reg  <= bus.xfer_rx;
              cnt_reg <= '0;
              if (bus.xfer_rx == 8'h00) begin
                state_reg <= TOKEN;
              end else begin
                err_reg   <= 1'b1;
                sd_ss_reg <= 1'b1;
                state_reg <= FIN;
              end
            end else if (cnt_reg == 12'(R1_LIMIT - 1)) begin
              to_reg    <= 1'b1;
              sd_ss_reg <= 1'b1;
              cnt_reg   <= '0;
              state_reg <= FIN;
            end else begin
              cnt_reg <= sat_inc(cnt_reg);
            end
          end
          TOKEN: begin
            if (bus.xfer_rx == TOKEN_START) begin
              cnt_reg   <= '0;
              state_reg <= DATA;
            end else if (bus.xfer_rx != 8'hFF) begin
              err_reg   <= 1'b1;
              sd_ss_reg <= 1'b1;
              cnt_reg   <= '0;
              state_reg <= FIN;
            end else if (cnt_reg == 12'(TOKEN_LIMIT - 1)) begin
              to_reg    <= 1'b1;
              sd_ss_reg <= 1'b1;
              cnt_reg   <= '0;
              state_reg <= FIN;
            end else begin
              cnt_reg <= sat_inc(cnt_reg);
            end
          end
          DATA: begin
            if (cnt_reg == 12'(SECTOR_BYTES - 1)) begin
              cnt_reg   <= '0;
              state_reg <= CRC;
            end else begin
              cnt_reg <= sat_inc(cnt_reg);
            end
          end
          CRC: begin
            if (cnt_reg == 12'(CRC_BYTES - 1)) begin
              sd_ss_reg <= 1'b1;
              cnt_reg   <= '0;
              state_reg <= FIN;
            end else begin
              cnt_reg <= sat_inc(cnt_reg);
            end
          end
          FIN: begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdcard_sector_reader.sv
// Self-checking bench for sdcard_sector_reader: a simple SPI byte-engine /
// card model answers from a scripted MISO stream, a sequence model predicts
// the MOSI stream, final status, R1 and sector contents.
module tb_sdcard_sector_reader;

  logic clk;
  logic rst;
  sdcard_sector_reader_if bus ();

  sdcard_sector_reader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Card stimulus and model predictions
  logic [7:0] script[$];
  logic [7:0] exp_mosi[$];
  logic       exp_ss[$];
  logic [7:0] exp_buf[512];
  logic [7:0] exp_r1 = 8'hFF;
  logic       exp_err;
  logic       exp_to;

  int exch_cnt = 0;   // written only by the card engine
  int exch_base = 0;  // written only by the main sequence
  int mon_cnt = 0;    // written only by the compare process
  int mon_base = 0;
  logic [7:0] last_tx = 8'hFF;
  logic [7:0] last_status;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] card(input int k);
    return (k < script.size()) ? script[k] : 8'hFF;
  endfunction

  // Expected exchange sequence derived from the protocol rules
  task automatic model_build(input logic [31:0] lba);
    int  k;
    bit  found;
    bit  got;
    logic [7:0] b;
    exp_mosi.delete();
    exp_ss.delete();
    exp_err = 1'b0;
    exp_to  = 1'b0;
    exp_mosi.push_back(8'h51);
    exp_mosi.push_back(lba[31:24]);
    exp_mosi.push_back(lba[23:16]);
    exp_mosi.push_back(lba[15:8]);
    exp_mosi.push_back(lba[7:0]);
    exp_mosi.push_back(8'hFF);
    repeat (6) exp_ss.push_back(1'b0);
    k = 6;
    found = 0;
    for (int n = 0; n < 8; n++) begin
      exp_mosi.push_back(8'hFF); exp_ss.push_back(1'b0);
      b = card(k); k++;
      if (!b[7]) begin exp_r1 = b; found = 1; break; end
    end
    if (!found) exp_to = 1'b1;
    else if (exp_r1 != 8'h00) exp_err = 1'b1;
    else begin
      got = 0;
      for (int n = 0; n < 4096; n++) begin
        exp_mosi.push_back(8'hFF); exp_ss.push_back(1'b0);
        b = card(k); k++;
        if (b == 8'hFE) begin got = 1; break; end
        if (b != 8'hFF) begin exp_err = 1'b1; break; end
      end
      if (!got && !exp_err) exp_to = 1'b1;
      if (got) begin
        for (int i = 0; i < 512; i++) begin
          exp_mosi.push_back(8'hFF); exp_ss.push_back(1'b0);
          exp_buf[i] = card(k); k++;
        end
        repeat (2) begin exp_mosi.push_back(8'hFF); exp_ss.push_back(1'b0); end
      end
    end
    exp_mosi.push_back(8'hFF);
    exp_ss.push_back(1'b1);
  endtask

  // SPI byte engine / card: busy for two cycles, then present the next MISO byte
  initial begin
    bus.xfer_busy = 1'b0;
    bus.xfer_rx   = 8'hFF;
    forever begin
      @(negedge clk);
      if (!rst && bus.xfer_start) begin
        @(posedge clk); #1 bus.xfer_busy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.xfer_rx   = card(exch_cnt - exch_base);
        bus.xfer_busy = 1'b0;
        exch_cnt++;
      end
    end
  end

  // Compare process: every started exchange and every busy cycle
  always @(negedge clk) begin
    if (!rst && bus.xfer_start) begin
      if (bus.xfer_busy) check("start_while_busy", 1, 0);
      if ((mon_cnt - mon_base) < exp_mosi.size()) begin
        check("mosi", bus.xfer_tx, exp_mosi[mon_cnt - mon_base]);
        check("sd_ss_xfer", bus.sd_ss, exp_ss[mon_cnt - mon_base]);
      end else begin
        check("extra_xfer", mon_cnt - mon_base, exp_mosi.size() - 1);
      end
      last_tx = bus.xfer_tx;
      mon_cnt++;
    end else if (!rst && bus.xfer_busy) begin
      check("tx_stable", bus.xfer_tx, last_tx);
    end
  end

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.rw = 1'b0; bus.AD = a; bus.DI = d;
    @(negedge clk);
    bus.cs = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.rw = 1'b1; bus.AD = a;
    @(negedge clk);
    bus.cs = 1'b0;
    d = bus.DO;
  endtask

  task automatic script_head();
    script.delete();
    repeat (6) script.push_back(8'hFF);
  endtask

  task automatic start_op(input logic [31:0] lba);
    cpu_write(3'd1, lba[31:24]);
    cpu_write(3'd2, lba[23:16]);
    cpu_write(3'd3, lba[15:8]);
    cpu_write(3'd4, lba[7:0]);
    model_build(lba);
    exch_base = exch_cnt;
    mon_base  = mon_cnt;
    cpu_write(3'd0, 8'h01);
  endtask

  task automatic finish_op(input string name);
    logic [7:0] st;
    logic [7:0] r;
    int polls;
    st = 8'h80;
    polls = 0;
    while (st[7] && polls < 15000) begin
      cpu_read(3'd0, st);
      polls++;
    end
    if (st[7]) check({name, "_busy_timeout"}, st, {1'b0, exp_err, exp_to, 5'b0});
    last_status = st;
    check({name, "_status"}, st, {1'b0, exp_err, exp_to, 5'b0});
    cpu_read(3'd6, r);
    check({name, "_r1"}, r, exp_r1);
    check({name, "_xfers"}, mon_cnt - mon_base, exp_mosi.size());
    check({name, "_sd_ss_end"}, bus.sd_ss, 1'b1);
    $display("op %s: status=%02h r1=%02h xfers=%0d", name, st, r, mon_cnt - mon_base);
  endtask

  initial begin
    logic [7:0] d;
    int n;
    rst = 1'b1;
    bus.cs = 1'b0; bus.rw = 1'b1; bus.AD = 3'd0; bus.DI = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_DO", bus.DO, 8'h00);
    check("rst_sd_ss", bus.sd_ss, 1'b1);
    check("rst_xfer_start", bus.xfer_start, 1'b0);
    check("rst_xfer_tx", bus.xfer_tx, 8'hFF);
    rst = 1'b0;
    cpu_read(3'd0, d); check("rst_status", d, 8'h00);
    cpu_read(3'd6, d); check("rst_r1", d, 8'hFF);
    cpu_read(3'd1, d); check("rst_lba3", d, 8'h00);
    $display("reset checks done");

    // Normal sector read, data byte i = i & 0xFF
    script_head();
    script.push_back(8'h00);
    script.push_back(8'hFE);
    for (int i = 0; i < 512; i++) script.push_back(8'(i));
    start_op(32'h0000_0010);
    finish_op("t1_read");
    check("t1_status_lit", last_status, 8'h00);
    cpu_read(3'd4, d); check("t1_lba0_readback", d, 8'h10);
    cpu_write(3'd5, 8'h00);
    for (int i = 0; i < 512; i++) begin
      cpu_read(3'd5, d);
      check("t1_data", d, exp_buf[i]);
      if (i == 255 || i == 511) check("t1_data_lit", d, 8'hFF);
      if (i == 256) check("t1_data_lit", d, 8'h00);
    end
    cpu_read(3'd5, d); check("t1_wrap", d, 8'h00);
    cpu_read(3'd5, d); check("t1_wrap1", d, 8'h01);
    $display("t1 512 data reads done");

    // R1 error
    script_head();
    script.push_back(8'hFF);
    script.push_back(8'h05);
    start_op(32'h0000_0020);
    finish_op("t2_r1err");
    check("t2_status_lit", last_status, 8'h40);
    cpu_read(3'd6, d); check("t2_r1_lit", d, 8'h05);
    check("t2_xfers_lit", mon_cnt - mon_base, 9);

    // MISO stuck high: R1 timeout after 8 bytes
    script_head();
    start_op(32'h0000_0030);
    finish_op("t3_r1_to");
    check("t3_status_lit", last_status, 8'h20);
    check("t3_xfers_lit", mon_cnt - mon_base, 15);

    // Token timeout after 4096 0xFF bytes
    script_head();
    script.push_back(8'h00);
    start_op(32'h0000_0040);
    finish_op("t4_tok_to");
    check("t4_status_lit", last_status, 8'h20);
    check("t4_xfers_lit", mon_cnt - mon_base, 4104);

    // Bad token
    script_head();
    script.push_back(8'h00);
    script.push_back(8'h08);
    start_op(32'h0000_0050);
    finish_op("t4_tok_err");
    check("t4b_status_lit", last_status, 8'h40);
    check("t4b_xfers_lit", mon_cnt - mon_base, 9);

    // GO, LBA write and data read while busy
    script_head();
    script.push_back(8'hFF); script.push_back(8'hFF);
    script.push_back(8'h00);
    script.push_back(8'hFF); script.push_back(8'hFE);
    for (int i = 0; i < 512; i++) script.push_back(8'hA5 ^ 8'(i));
    start_op(32'h1234_5678);
    cpu_read(3'd5, d); check("t5_busy_read", d, 8'hFF);
    cpu_write(3'd0, 8'h01);
    cpu_write(3'd1, 8'h99);
    finish_op("t5_busy_go");
    cpu_read(3'd1, d); check("t5_lba_kept", d, 8'h12);
    cpu_read(3'd5, d); check("t5_ptr0", d, exp_buf[0]);
    check("t5_ptr0_lit", d, 8'hA5);
    cpu_read(3'd5, d); check("t5_ptr1_lit", d, 8'hA4);

    // Reset in the middle of DATA
    script_head();
    script.push_back(8'h00);
    script.push_back(8'hFE);
    for (int i = 0; i < 512; i++) script.push_back(8'(i + 3));
    start_op(32'h0000_0060);
    n = 0;
    while ((mon_cnt - mon_base) < 109 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_data", (mon_cnt - mon_base) >= 109, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_DO", bus.DO, 8'h00);
    check("t6_sd_ss", bus.sd_ss, 1'b1);
    check("t6_xfer_start", bus.xfer_start, 1'b0);
    check("t6_xfer_tx", bus.xfer_tx, 8'hFF);
    rst = 1'b0;
    cpu_read(3'd0, d); check("t6_status", d, 8'h00);
    cpu_read(3'd4, d); check("t6_lba0", d, 8'h00);
    cpu_read(3'd6, d); check("t6_r1", d, 8'hFF);
    $display("t6 mid-data reset done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
